// File: rtl/fpga_scope_pkg.sv
// Shared FSM state type and ADC frame constants for the FPGA scope.
// Imported by fpga_scope_top; no ports.
package fpga_scope_pkg;

  typedef enum logic [2:0] {
    S_AMP,
    S_IDLE,
    S_CONV,
    S_READ,
    S_OUT
  } state_t;

  localparam int ADC_FRAME_BITS = 34;
  localparam int ADC_A_FIRST    = 3;
  localparam int ADC_A_LAST     = 16;

  localparam logic [7:0] DEF_AMP_GAIN = 8'h11;

endpackage

// File: rtl/clk_divider.sv
// Clock-enable divider: one-clk tick every DIV cycles while en is high.
// Ports: clk, rst (sync, active high), en (low holds count at 0), tick.
module clk_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpga_scope_top.sv
// FPGA scope top: sends LTC6912 gain once after reset, then loops
// LTC1407A conversions and shows sample A [13:6] on ledy.
// Ports: clk, rst (sync, active high), AMP_DOUT (unused), AD_DOUT,
//   TXD, SPI_MOSI, AMP_CS, SPI_SCK, AD_CONV, AMP_SHDN, ledy[7:0].
// Build option: SCOPE_UART_EN adds an 8N1 UART echo of ledy on TXD.
module fpga_scope_top
  import fpga_scope_pkg::*;
#(
  parameter int         SPI_DIV    = 4,
  parameter logic [7:0] AMP_GAIN   = DEF_AMP_GAIN,
  parameter int         SAMPLE_DIV = 1000,
  parameter int         BAUD_DIV   = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AMP_DOUT,
  input  logic       AD_DOUT,
  output logic       TXD,
  output logic       SPI_MOSI,
  output logic       AMP_CS,
  output logic       SPI_SCK,
  output logic       AD_CONV,
  output logic       AMP_SHDN,
  output logic [7:0] ledy
);

  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  state_t        state;
  logic [5:0]    bit_cnt;
  logic          sck;
  logic          mosi;
  logic          amp_cs;
  logic          ad_conv;
  logic [13:0]   sample;
  logic [SW-1:0] samp_cnt;
  logic          tick;
  logic          div_en;
  logic          rise;
  logic          fall;
  logic [2:0]    amp_bit;
  logic          uart_idle;
  logic          unused_amp_dout;

  assign unused_amp_dout = AMP_DOUT;

  assign div_en = (state == S_AMP)
               || (state == S_CONV)
               || (state == S_READ);

  clk_divider #(
    .DIV (SPI_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .tick (tick)
  );

  assign rise = tick && !sck;
  assign fall = tick && sck;

  // MSB first; on a fall the next bit is presented.
  assign amp_bit = ~(bit_cnt[2:0] + {2'b00, fall});

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_AMP;
      bit_cnt  <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      amp_cs   <= 1'b1;
      ad_conv  <= 1'b0;
      sample   <= '0;
      samp_cnt <= '0;
      ledy     <= '0;
    end else begin
      if (tick) begin
        sck <= ~sck;
      end else if (!div_en) begin
        sck <= 1'b0;
      end
      // Saturating, so the conversion rate spans the whole frame.
      if (samp_cnt != SW'(SAMPLE_DIV - 1)) begin
        samp_cnt <= samp_cnt + 1'b1;
      end
      unique case (state)
        S_AMP: begin
          amp_cs <= 1'b0;
          mosi   <= AMP_GAIN[amp_bit];
          if (fall) begin
            if (bit_cnt == 6'd7) begin
              amp_cs  <= 1'b1;
              mosi    <= 1'b0;
              bit_cnt <= '0;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_IDLE: begin
          mosi   <= 1'b0;
          amp_cs <= 1'b1;
          if (samp_cnt == SW'(SAMPLE_DIV - 1)
              && uart_idle) begin
            samp_cnt <= '0;
            ad_conv  <= 1'b1;
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          if (fall) begin
            ad_conv <= 1'b0;
            bit_cnt <= '0;
            state   <= S_READ;
          end
        end
        S_READ: begin
          // bit_cnt is the number of rises already seen.
          if (rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt >= 6'(ADC_A_FIRST - 1)
                && bit_cnt <= 6'(ADC_A_LAST - 1)) begin
              sample <= {sample[12:0], AD_DOUT};
            end
          end else if (fall
              && bit_cnt == 6'(ADC_FRAME_BITS)) begin
            state <= S_OUT;
          end
        end
        S_OUT: begin
          ledy    <= sample[13:6];
          bit_cnt <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_AMP;
      endcase
    end
  end

`ifdef SCOPE_UART_EN
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic          tx_busy;
  logic          txd;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    tx_idx;
  logic [7:0]    tx_shift;

  assign uart_idle = !tx_busy;
  assign TXD       = txd;

  // tx_idx 0 is the start bit, 1..8 data, 9 stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      txd      <= 1'b1;
      baud_cnt <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else if (state == S_OUT) begin
      tx_busy  <= 1'b1;
      txd      <= 1'b0;
      baud_cnt <= '0;
      tx_idx   <= '0;
      tx_shift <= sample[13:6];
    end else if (tx_busy) begin
      if (baud_cnt == BW'(BAUD_DIV - 1)) begin
        baud_cnt <= '0;
        if (tx_idx == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_idx   <= tx_idx + 1'b1;
          txd      <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[7:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end
`else
  assign uart_idle = 1'b1;
  assign TXD       = 1'b1;
`endif

  assign SPI_MOSI = mosi;
  assign AMP_CS   = amp_cs;
  assign SPI_SCK  = sck;
  assign AD_CONV  = ad_conv;
  assign AMP_SHDN = 1'b0;

endmodule

// File: tb/tb_fpga_scope_top.sv
// Directed bench for fpga_scope_top: reset, gain write, ADC frames,
// optional UART echo (SCOPE_UART_EN) and reset during a read.
module tb_fpga_scope_top;

  logic       clk;
  logic       rst;
  logic       amp_dout;
  logic       ad_dout;
  logic       txd;
  logic       spi_mosi;
  logic       amp_cs;
  logic       spi_sck;
  logic       ad_conv;
  logic       amp_shdn;
  logic [7:0] ledy;

  int n_cmp;
  int n_bad;

  fpga_scope_top dut (
    .clk      (clk),
    .rst      (rst),
    .AMP_DOUT (amp_dout),
    .AD_DOUT  (ad_dout),
    .TXD      (txd),
    .SPI_MOSI (spi_mosi),
    .AMP_CS   (amp_cs),
    .SPI_SCK  (spi_sck),
    .AD_CONV  (ad_conv),
    .AMP_SHDN (amp_shdn),
    .ledy     (ledy)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic amp_check();
    int   n;
    int   cyc;
    int   rises;
    int   t0;
    int   t1;
    logic prev;
    logic [7:0] byte_seen;
    n = 0;
    while (amp_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("amp_cs_low", amp_cs, 0);
    cyc = 0;
    rises = 0;
    t0 = 0;
    t1 = 0;
    byte_seen = '0;
    prev = spi_sck;
    while (!amp_cs && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (spi_sck && !prev) begin
        rises++;
        byte_seen = {byte_seen[6:0], spi_mosi};
        if (rises == 1) t0 = cyc;
        if (rises == 2) t1 = cyc;
      end
      prev = spi_sck;
    end
    check("amp_rises", rises, 8);
    check("amp_byte", byte_seen, 8'h11);
    check("sck_period", t1 - t0, 8);
    check("amp_cs_end", amp_cs, 1);
    @(negedge clk);
    check("mosi_idle", spi_mosi, 0);
  endtask

  task automatic run_frame(input logic [33:0] frame,
                           output int conv_w,
                           output int rises);
    int   n;
    logic prev;
    conv_w = 0;
    rises = 0;
    ad_dout = frame[33];
    n = 0;
    while (!ad_conv && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("conv_seen", ad_conv, 1);
    while (ad_conv && conv_w < 100) begin
      conv_w++;
      @(negedge clk);
    end
    prev = spi_sck;
    n = 0;
    while (!(rises == 34 && !spi_sck) && n < 400) begin
      @(negedge clk);
      n++;
      if (spi_sck && !prev) rises++;
      prev = spi_sck;
      ad_dout = (rises < 34) ? frame[33 - rises] : 1'b0;
    end
    @(negedge clk);
  endtask

  int   w;
  int   r;
  int   n;
  logic conv_hit;
  logic [7:0] ub;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    amp_dout = 1'b0;
    ad_dout = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_mosi", spi_mosi, 0);
    check("rst_cs", amp_cs, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_conv", ad_conv, 0);
    check("rst_shdn", amp_shdn, 0);
    check("rst_ledy", ledy, 0);
    rst = 1'b0;

    amp_check();

    run_frame({34{1'b1}}, w, r);
    check("conv_width", w, 8);
    check("read_rises", r, 34);
    check("ledy_ones", ledy, 8'hFF);

    run_frame({34{1'b0}}, w, r);
    check("read_rises0", r, 34);
    check("ledy_zeros", ledy, 8'h00);

    // Ignored rises carry ones to prove they are discarded.
    run_frame({2'b11, 14'h2A55, 18'h3FFFF}, w, r);
    check("conv_width2", w, 8);
    check("ledy_2a55", ledy, 8'hA9);

`ifdef SCOPE_UART_EN
    ub = 8'hA9;
    conv_hit = 1'b0;
    repeat (217) begin
      @(negedge clk);
      if (ad_conv) conv_hit = 1'b1;
    end
    check("uart_start", txd, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (434) begin
        @(negedge clk);
        if (ad_conv) conv_hit = 1'b1;
      end
      check($sformatf("uart_d%0d", i), txd, ub[i]);
    end
    repeat (434) begin
      @(negedge clk);
      if (ad_conv) conv_hit = 1'b1;
    end
    check("uart_stop", txd, 1);
    check("conv_during_uart", conv_hit, 0);
    n = 0;
    while (!ad_conv && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("conv_after_stop", ad_conv, 1);
`else
    check("txd_idle", txd, 1);
`endif

    n = 0;
    while (!ad_conv && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("conv_seen_rst", ad_conv, 1);
    n = 0;
    while (ad_conv && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (100) @(negedge clk);
    check("ledy_hold", ledy, 8'hA9);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cs", amp_cs, 1);
    check("mid_rst_conv", ad_conv, 0);
    check("mid_rst_sck", spi_sck, 0);
    check("mid_rst_ledy", ledy, 0);
    rst = 1'b0;
    amp_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
